// File: rtl/ahb_pkg.sv
// rtl/ahb_pkg.sv - shared AHB encodings, select-register and default-slave types
package ahb_pkg;

   localparam int NUM_SLAVES_DEF = 4;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // Data-phase owner: nobody, decoded slave <idx>, or the internal default slave.
   typedef enum logic [1:0] {SEL_NONE, SEL_SLV, SEL_DEFAULT} sel_kind_e;

   typedef struct packed {
      sel_kind_e  kind;
      logic [7:0] idx;
   } sel_t;

   typedef enum logic [1:0] {DS_IDLE, DS_ERR1, DS_ERR2} ds_state_e;

   function automatic logic trans_active(input logic [1:0] t);
      case (t)
         HTRANS_NONSEQ, HTRANS_SEQ: return 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  return 1'b0;
         default:                   return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// rtl/ahb_default_slave.sv - two-cycle ERROR responder for unmapped transfers plus saturating error counter
module ahb_default_slave
   import ahb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       hready,
   input  logic       start_err,
   output logic       ds_hready,
   output logic       ds_hresp,
   output logic [7:0] errcnt
);

   ds_state_e  state_q, state_d;
   logic [7:0] errcnt_q, errcnt_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= DS_IDLE;
         errcnt_q <= 8'd0;
      end else begin
         state_q  <= state_d;
         errcnt_q <= errcnt_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      errcnt_d = errcnt_q;
      case (state_q)
         DS_ERR1: state_d = DS_ERR2;
         default: begin
            if (start_err)
               state_d = DS_ERR1;
            else if (hready)
               state_d = DS_IDLE;
         end
      endcase
      // ERR1 always lasts exactly one cycle, so entering it is a new error response.
      if (state_d == DS_ERR1 && state_q != DS_ERR1 && errcnt_q != 8'hFF)
         errcnt_d = errcnt_q + 8'd1;
   end

   assign ds_hready = (state_q != DS_ERR1);
   assign ds_hresp  = (state_q != DS_IDLE) ? HRESP_ERROR : HRESP_OKAY;
   assign errcnt    = errcnt_q;

endmodule

// File: rtl/ahb_resp_mux.sv
// rtl/ahb_resp_mux.sv - AHB data-phase select register and slave response multiplexer
module ahb_resp_mux
   import ahb_pkg::*;
#(
   parameter int NUM_SLAVES = NUM_SLAVES_DEF,
   parameter int DATA_W     = 32
) (
   input  logic                         HCLK,
   input  logic                         HRESET,
   input  logic [NUM_SLAVES-1:0]        HSELx,
   input  logic                         HERROR,
   input  logic [1:0]                   HTRANS,
   input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
   input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
   input  logic [NUM_SLAVES-1:0]        HRESP_S,
   output logic [DATA_W-1:0]            HRDATA,
   output logic                         HREADY,
   output logic                         HRESP,
   output logic [7:0]                   ERRCNT
);

   sel_t       sel_q, sel_d, sel_addr;
   logic [7:0] hit_idx;
   logic       ds_hready, ds_hresp;

   always_comb begin
      hit_idx = 8'd0;
      for (int i = 0; i < NUM_SLAVES; i++)
         if (HSELx[i]) hit_idx = 8'(i);

      // A decoder error overrides any select lines it may have raised.
      if (!HERROR && $onehot(HSELx))
         sel_addr = '{kind: SEL_SLV, idx: hit_idx};
      else if (trans_active(HTRANS))
         sel_addr = '{kind: SEL_DEFAULT, idx: 8'd0};
      else
         sel_addr = '{kind: SEL_NONE, idx: 8'd0};

      sel_d = HREADY ? sel_addr : sel_q;
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET)
         sel_q <= '{kind: SEL_NONE, idx: 8'd0};
      else
         sel_q <= sel_d;
   end

   ahb_default_slave u_default_slave (
      .clk       (HCLK),
      .rst       (HRESET),
      .hready    (HREADY),
      .start_err (HREADY && sel_addr.kind == SEL_DEFAULT),
      .ds_hready (ds_hready),
      .ds_hresp  (ds_hresp),
      .errcnt    (ERRCNT)
   );

   always_comb begin
      HRDATA = '0;
      HREADY = 1'b1;
      HRESP  = HRESP_OKAY;
      case (sel_q.kind)
         SEL_SLV: begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
               if (sel_q.idx == 8'(i)) begin
                  HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
                  HREADY = HREADYOUT_S[i];
                  HRESP  = HRESP_S[i];
               end
            end
         end
         SEL_DEFAULT: begin
            HREADY = ds_hready;
            HRESP  = ds_hresp;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb/tb_ahb_resp_mux.sv - directed vector bench for ahb_resp_mux
module tb_ahb_resp_mux;
   import ahb_pkg::*;

   logic         HCLK = 1'b0;
   logic         HRESET;
   logic [3:0]   HSELx;
   logic         HERROR;
   logic [1:0]   HTRANS;
   logic [127:0] HRDATA_S;
   logic [3:0]   HREADYOUT_S;
   logic [3:0]   HRESP_S;
   logic [31:0]  HRDATA;
   logic         HREADY;
   logic         HRESP;
   logic [7:0]   ERRCNT;

   int n_checks = 0;
   int n_fail   = 0;

   ahb_resp_mux #(.NUM_SLAVES(4), .DATA_W(32)) dut (
      .HCLK        (HCLK),
      .HRESET      (HRESET),
      .HSELx       (HSELx),
      .HERROR      (HERROR),
      .HTRANS      (HTRANS),
      .HRDATA_S    (HRDATA_S),
      .HREADYOUT_S (HREADYOUT_S),
      .HRESP_S     (HRESP_S),
      .HRDATA      (HRDATA),
      .HREADY      (HREADY),
      .HRESP       (HRESP),
      .ERRCNT      (ERRCNT)
   );

   always #5 HCLK = ~HCLK;

   typedef struct {
      logic [3:0]  hsel;
      logic        herror;
      logic [1:0]  htrans;
      logic [3:0]  rdy;
      logic [3:0]  resp;
      logic        exp_rdy;
      logic        exp_resp;
      logic [31:0] exp_data;
      logic [7:0]  exp_cnt;
   } vec_t;

   localparam logic [31:0] D0 = 32'hA0A0A0A0;
   localparam logic [31:0] D1 = 32'hDEADBEEF;
   localparam logic [31:0] D2 = 32'hC2C2C2C2;
   localparam logic [31:0] D3 = 32'h33333333;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic [3:0] hsel, input logic herror, input logic [1:0] htrans);
      HSELx  = hsel;
      HERROR = herror;
      HTRANS = htrans;
   endtask

   initial begin
      HRESET      = 1'b1;
      HSELx       = 4'b0000;
      HERROR      = 1'b0;
      HTRANS      = HTRANS_IDLE;
      HRDATA_S    = {D3, D2, D1, D0};
      HREADYOUT_S = 4'b1111;
      HRESP_S     = 4'b0000;

      //            hsel     herr  htrans         rdy      resp     erdy  eresp edata  ecnt
      vecs[0]  = '{4'b0010, 1'b0, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0, 8'd0};
      vecs[1]  = '{4'b0000, 1'b0, HTRANS_IDLE,   4'b1111, 4'b0000, 1'b1, 1'b0, D1,    8'd0};
      vecs[2]  = '{4'b0000, 1'b1, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0, 8'd0};
      vecs[3]  = '{4'b0100, 1'b0, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 32'h0, 8'd1};
      vecs[4]  = '{4'b0100, 1'b0, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b1, 32'h0, 8'd1};
      vecs[5]  = '{4'b0001, 1'b0, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, D2,    8'd1};
      vecs[6]  = '{4'b0100, 1'b0, HTRANS_NONSEQ, 4'b1110, 4'b0000, 1'b0, 1'b0, D0,    8'd1};
      vecs[7]  = '{4'b0100, 1'b0, HTRANS_NONSEQ, 4'b1110, 4'b0000, 1'b0, 1'b0, D0,    8'd1};
      vecs[8]  = '{4'b0100, 1'b0, HTRANS_NONSEQ, 4'b1110, 4'b0000, 1'b0, 1'b0, D0,    8'd1};
      vecs[9]  = '{4'b0100, 1'b0, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, D0,    8'd1};
      vecs[10] = '{4'b0000, 1'b1, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b1, 1'b0, D2,    8'd1};
      vecs[11] = '{4'b0110, 1'b0, HTRANS_NONSEQ, 4'b1111, 4'b0000, 1'b0, 1'b1, 32'h0, 8'd2};
      vecs[12] = '{4'b0110, 1'b0, HTRANS_SEQ,    4'b1111, 4'b0000, 1'b1, 1'b1, 32'h0, 8'd2};
      vecs[13] = '{4'b0000, 1'b0, HTRANS_BUSY,   4'b1111, 4'b0000, 1'b0, 1'b1, 32'h0, 8'd3};
      vecs[14] = '{4'b0000, 1'b0, HTRANS_BUSY,   4'b1111, 4'b0000, 1'b1, 1'b1, 32'h0, 8'd3};
      vecs[15] = '{4'b1000, 1'b0, HTRANS_IDLE,   4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0, 8'd3};
      vecs[16] = '{4'b0000, 1'b0, HTRANS_IDLE,   4'b0111, 4'b1000, 1'b0, 1'b1, D3,    8'd3};
      vecs[17] = '{4'b0000, 1'b0, HTRANS_IDLE,   4'b1111, 4'b1000, 1'b1, 1'b1, D3,    8'd3};
      vecs[18] = '{4'b0000, 1'b0, HTRANS_IDLE,   4'b1111, 4'b0000, 1'b1, 1'b0, 32'h0, 8'd3};

      #2;
      check("reset_hready", 32'(HREADY), 32'd1);
      check("reset_hresp",  32'(HRESP),  32'd0);
      check("reset_hrdata", HRDATA,      32'h0);
      check("reset_errcnt", 32'(ERRCNT), 32'd0);
      step();
      step();
      HRESET = 1'b0;

      for (int i = 0; i < 19; i++) begin
         drive(vecs[i].hsel, vecs[i].herror, vecs[i].htrans);
         HREADYOUT_S = vecs[i].rdy;
         HRESP_S     = vecs[i].resp;
         #1;
         check($sformatf("vec%0d_hready", i), 32'(HREADY), 32'(vecs[i].exp_rdy));
         check($sformatf("vec%0d_hresp", i),  32'(HRESP),  32'(vecs[i].exp_resp));
         check($sformatf("vec%0d_hrdata", i), HRDATA,      vecs[i].exp_data);
         check($sformatf("vec%0d_errcnt", i), 32'(ERRCNT), 32'(vecs[i].exp_cnt));
         step();
      end

      // Saturation: a continuous stream of unmapped NONSEQ transfers.
      HRESET = 1'b1;
      #1;
      HRESET = 1'b0;
      HREADYOUT_S = 4'b1111;
      HRESP_S     = 4'b0000;
      drive(4'b0000, 1'b0, HTRANS_NONSEQ);
      #1;
      check("sat_first_none", {29'd0, HREADY, HRESP, |HRDATA}, {29'd0, 1'b1, 1'b0, 1'b0});
      step();
      for (int k = 1; k <= 300; k++) begin
         check($sformatf("sat_err1_%0d", k), {22'd0, HREADY, HRESP, ERRCNT},
               {22'd0, 1'b0, 1'b1, (k > 255) ? 8'd255 : 8'(k)});
         step();
         check($sformatf("sat_err2_%0d", k), {30'd0, HREADY, HRESP}, {30'd0, 1'b1, 1'b1});
         step();
      end
      check("sat_final_errcnt", 32'(ERRCNT), 32'd255);

      // Bus is now in ERR1 again; an asynchronous reset must abort the response.
      check("pre_rst_err1", {30'd0, HREADY, HRESP}, {30'd0, 1'b0, 1'b1});
      #2;
      HRESET = 1'b1;
      #1;
      check("rst_async", {21'd0, HREADY, HRESP, |HRDATA, ERRCNT}, {21'd0, 1'b1, 1'b0, 1'b0, 8'd0});
      step();
      drive(4'b0000, 1'b0, HTRANS_IDLE);
      HRESET = 1'b0;
      #1;
      check("rst_release", {21'd0, HREADY, HRESP, |HRDATA, ERRCNT}, {21'd0, 1'b1, 1'b0, 1'b0, 8'd0});
      step();
      check("rst_post_cycle", {21'd0, HREADY, HRESP, |HRDATA, ERRCNT}, {21'd0, 1'b1, 1'b0, 1'b0, 8'd0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ahb_resp_mux.md
AHB_RESP_MUX -- requirements
Module: ahb_resp_mux

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 4, number of decoded slave ports.
REQ-002 SHALL have parameter DATA_W, default 32, read-data width.
REQ-003 SHALL have port HCLK  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port HRESET  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port HSELx  input  NUM_SLAVES  address-phase one-hot slave selects from decoder.
REQ-006 SHALL have port HERROR  input  1  address-phase "no slave matched" flag from decoder.
REQ-007 SHALL have port HTRANS  input  2  master transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11).
REQ-008 SHALL have port HRDATA_S  input  NUM_SLAVES*DATA_W  packed slave read data, slave i at bits [i*DATA_W +: DATA_W].
REQ-009 SHALL have port HREADYOUT_S  input  NUM_SLAVES  per-slave ready.
REQ-010 SHALL have port HRESP_S  input  NUM_SLAVES  per-slave response (0=OKAY, 1=ERROR).
REQ-011 SHALL have port HRDATA  output  DATA_W  read data to master.
REQ-012 SHALL have port HREADY  output  1  bus ready to master and to all slaves.
REQ-013 SHALL have port HRESP  output  1  response to master.
REQ-014 SHALL have port ERRCNT  output  8  saturating count of default-slave ERROR responses.

Function
REQ-015 SHALL capture a data-phase select register sel_q only on HCLK rising edges where HREADY=1.
REQ-016 SHALL load sel_q = slave i when HSELx is exactly one-hot with bit i set, regardless of HTRANS.
REQ-017 SHALL load sel_q = DEFAULT when HSELx is zero or multi-hot, or HERROR=1, and HTRANS is NONSEQ or SEQ.
REQ-018 SHALL load sel_q = NONE when HSELx is zero or multi-hot, or HERROR=1, and HTRANS is IDLE or BUSY.
REQ-019 SHALL, with sel_q=slave i, drive HRDATA/HREADY/HRESP combinationally from slave i's signals; zero added latency.
REQ-020 SHALL, with sel_q=NONE, drive HREADY=1, HRESP=0, HRDATA=0.
REQ-021 SHALL implement a default-slave FSM with states IDLE, ERR1, ERR2.
REQ-022 SHALL transition IDLE->ERR1 on the same HREADY=1 edge that loads sel_q=DEFAULT.
REQ-023 SHALL, in ERR1, drive HREADY=0, HRESP=1, HRDATA=0; ERR1->ERR2 unconditionally next cycle.
REQ-024 SHALL, in ERR2, drive HREADY=1, HRESP=1, HRDATA=0; from ERR2 go to ERR1 if the newly captured sel_q is DEFAULT, else IDLE.
REQ-025 SHALL ignore HSELx/HERROR/HTRANS while HREADY=0 (ERR1 or waited slave); sel_q holds.
REQ-026 SHALL increment ERRCNT by 1 on each ERR1 entry, saturating at 255 with no wrap.
REQ-027 SHALL support back-to-back transfers: a slave-i data phase completing with HREADY=1 while the next address hits DEFAULT starts ERR1 the following cycle.
REQ-028 SHALL pass through a slave's own two-cycle ERROR unchanged; it SHALL NOT count in ERRCNT.

Reset
REQ-029 SHALL, while HRESET=1, force sel_q=NONE, FSM=IDLE, ERRCNT=0 asynchronously.
REQ-030 SHALL drive HREADY=1, HRESP=0, HRDATA=0 during and immediately after reset.
REQ-031 SHALL, on reset asserted mid-ERR1/ERR2, abort the error response; the first post-reset cycle is NONE.

Structure
REQ-032 SHALL take HTRANS and HRESP encodings, NUM_SLAVES default, and the sel_q enum type (NONE, SLV0..SLVn-1, DEFAULT) from shared package ahb_pkg.
REQ-033 SHALL place the IDLE/ERR1/ERR2 FSM and ERRCNT in sub-module ahb_default_slave; select register and mux stay in ahb_resp_mux.

Verification
REQ-034 SHALL verify: HSELx=0010, HTRANS=NONSEQ, HREADYOUT_S[1]=1, HRDATA_S slot1=0xDEADBEEF -> next cycle HRDATA=0xDEADBEEF, HREADY=1, HRESP=0.
REQ-035 SHALL verify: HERROR=1, HSELx=0000, HTRANS=NONSEQ -> next cycle HREADY=0/HRESP=1, then HREADY=1/HRESP=1, ERRCNT=1.
REQ-036 SHALL verify: HSELx=0001 with slave0 HREADYOUT_S=0 for 3 cycles while HSELx changes to 0100 -> HREADY low 3 cycles, sel_q stays slave0, slave2 selected only after HREADY=1.
REQ-037 SHALL verify: HSELx=0000, HTRANS=IDLE -> HREADY=1, HRESP=0, HRDATA=0, ERRCNT unchanged.
REQ-038 SHALL verify: 300 consecutive unmapped NONSEQ transfers -> ERRCNT=255, every transfer gets the two-cycle ERROR.
REQ-039 SHALL verify: HRESET asserted during ERR1 -> HREADY=1, HRESP=0, ERRCNT=0 immediately and in the first cycle after release.
